// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default sizes for the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      INIT = 1'b1
   } state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : regfile_init_seq
// Description : Walks every entry once, writing entry i with value i.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_init_seq
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_req,
   output logic              seq_we,
   output logic [ADDR_W-1:0] seq_addr,
   output logic [DATA_W-1:0] seq_data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      seq_we   = 1'b0;
      seq_addr = cnt_q;
      seq_data = DATA_W'(cnt_q);
      case (state_q)
         IDLE: begin
            if (init_req) begin
               state_d = INIT;
               cnt_d   = '0;
            end
         end
         INIT: begin
            // init_req is deliberately not examined here: no restart or extension
            seq_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == INIT);
   assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : 1W/2R register file with registered reads and a reinit sequencer.
//               Optional write-through on reads: define REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              init_req,
   output logic              init_busy,
   output logic              init_done
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

   logic              seq_we;
   logic [ADDR_W-1:0] seq_addr;
   logic [DATA_W-1:0] seq_data;
   logic              seq_busy;
   logic              wr_acc;

   regfile_init_seq #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_init_seq (
      .clk      (clk),
      .rst      (rst),
      .init_req (init_req),
      .seq_we   (seq_we),
      .seq_addr (seq_addr),
      .seq_data (seq_data),
      .busy     (seq_busy),
      .done     (init_done)
   );

   assign init_busy = seq_busy;
   assign wr_acc    = we && !seq_busy;

   always_comb begin
      mem_d = mem_q;
      if (seq_we) begin
         mem_d[seq_addr] = seq_data;
      end else if (wr_acc) begin
         mem_d[waddr] = wdata;
      end
   end

   // Sequencer writes are never forwarded; only accepted user writes bypass.
   always_comb begin
      rdata_a_d = mem_q[raddr_a];
      rdata_b_d = mem_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_acc && (raddr_a == waddr)) rdata_a_d = wdata;
      if (wr_acc && (raddr_b == waddr)) rdata_b_d = wdata;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= DATA_W'(i);
         end
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         mem_q     <= mem_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each entry in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; depth DEPTH = 2**ADDR_W is a derived localparam.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port we, input, 1: write enable.
REQ-006 SHALL have port waddr, input, ADDR_W: write address.
REQ-007 SHALL have port wdata, input, DATA_W: write data.
REQ-008 SHALL have port raddr_a, input, ADDR_W: read port A address.
REQ-009 SHALL have port rdata_a, output, DATA_W: read port A data, registered.
REQ-010 SHALL have port raddr_b, input, ADDR_W: read port B address.
REQ-011 SHALL have port rdata_b, output, DATA_W: read port B data, registered.
REQ-012 SHALL have port init_req, input, 1: request to reinitialise all entries.
REQ-013 SHALL have port init_busy, output, 1: reinitialisation in progress.
REQ-014 SHALL have port init_done, output, 1: one-cycle pulse when reinitialisation completes.

Function
REQ-015 SHALL hold DEPTH entries of DATA_W bits; the initial value of entry i is i truncated to DATA_W bits.
REQ-016 SHALL write wdata into entry waddr at a clock edge where we=1 and init_busy=0.
REQ-017 SHALL ignore we while init_busy=1; the write is dropped, not queued.
REQ-018 SHALL present on rdata_x, one cycle after the edge, the contents of entry raddr_x sampled at that edge (latency 1).
REQ-019 SHALL serve both read ports independently, including with equal addresses.
REQ-020 SHALL run a state machine with states IDLE and INIT; IDLE is the reset state.
REQ-021 SHALL move from IDLE to INIT when init_req=1 in IDLE, clearing the sequence counter cnt to 0.
REQ-022 SHALL, in INIT, write entry cnt with value cnt (truncated) on each cycle and then increment cnt.
REQ-023 SHALL leave INIT for IDLE after writing entry DEPTH-1, asserting init_done for exactly that following cycle.
REQ-024 SHALL drive init_busy=1 in every INIT cycle, 0 otherwise; init_busy covers exactly DEPTH cycles.
REQ-025 SHALL ignore init_req while in INIT (no restart, no extension).
REQ-026 SHALL, in INIT, return stored contents on read ports; forwarding of sequencer writes is not performed.
REQ-027 SHALL, when init_req=1 and we=1 in the same IDLE cycle, perform the write and enter INIT; the sequencer later overwrites that entry.

Reset
REQ-028 SHALL, on rst=1 and asynchronously, restore every entry to its REQ-015 value.
REQ-029 SHALL, on rst, drive rdata_a=0, rdata_b=0, init_busy=0, init_done=0, state=IDLE and cnt=0.
REQ-030 SHALL abandon an in-progress INIT on rst, with no init_done pulse.

Configuration
REQ-031 SHALL use macro REGFILE_BYPASS_EN.
REQ-032 SHALL, when REGFILE_BYPASS_EN is defined, return wdata on rdata_x if an accepted write and raddr_x==waddr occur at the same edge (write-through).
REQ-033 SHALL, without REGFILE_BYPASS_EN, return the pre-write contents in that case.

Structure
REQ-034 SHALL place the state enum (IDLE, INIT) and the DATA_W/ADDR_W defaults in package regfile_pkg.
REQ-035 SHALL implement the FSM and counter in sub-module regfile_init_seq, which outputs seq_we, seq_addr, seq_data, busy and done.

Verification
REQ-036 SHALL check: after reset, read addr 5 on A and 15 on B -> next cycle rdata_a=0x05, rdata_b=0x0F.
REQ-037 SHALL check: write 0xA5 to addr 3, then read A=3 next edge -> rdata_a=0xA5; entry 4 stays 0x04.
REQ-038 SHALL check: write 0x3C to addr 7 with raddr_a=7 at the same edge -> rdata_a=0x3C with REGFILE_BYPASS_EN, 0x07 without.
REQ-039 SHALL check: write 0xFF to all entries, pulse init_req -> init_busy high exactly 16 cycles, init_done single pulse, all entries read back i.
REQ-040 SHALL check: we=1 to addr 2 with 0x99 during INIT -> write dropped, entry 2 reads 0x02 after done.
REQ-041 SHALL check: assert rst at INIT cycle 6 after writing 0xEE to addr 12 -> init_busy=0 immediately, no init_done, entry 12 reads 0x0C.
